// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that handles STEP bits per clock, LSB first,
// through STEP chained full-adder cells with a registered carry between steps.
// An operation takes N = WIDTH/STEP cycles from the accepting edge to the done pulse.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request; sampled only in IDLE or DONE
//   sub    in   0: a + b + cin, 1: a - b (a + ~b + 1, cin ignored)
//   cin    in   carry-in for add mode
//   a, b   in   operands, captured on the accepting edge
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse, result valid
//   sum    out  result register (updates only on the final step)
//   cout   out  carry-out of MSB (sub mode: 1 = no borrow)
//   ovf    out  two's-complement signed overflow
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if ((STEP == 0) || (WIDTH < 2) || ((WIDTH % STEP) != 0)) begin : g_param_check
        $fatal(1, "serial_adder: WIDTH must be >= 2 and a multiple of STEP");
    end

    localparam int unsigned N    = WIDTH / STEP;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  psum_q, psum_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [STEP:0]       chain_c;
    logic [STEP-1:0]     step_sum;
    logic [WIDTH+STEP-1:0] psum_cat;

    // Full-adder cell chain over the low STEP bits of the operand shift registers.
    always_comb begin
        chain_c[0] = carry_q;
        for (int i = 0; i < int'(STEP); i++) begin
            step_sum[i]  = a_q[i] ^ b_q[i] ^ chain_c[i];
            chain_c[i+1] = (a_q[i] & b_q[i]) | (chain_c[i] & (a_q[i] ^ b_q[i]));
        end
    end

    // New result bits enter at the MSB end; after N steps the word is in place.
    assign psum_cat = {step_sum, psum_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    state_d = StRun;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                a_d     = a_q >> STEP;
                b_d     = b_q >> STEP;
                carry_d = chain_c[STEP];
                psum_d  = psum_cat[WIDTH+STEP-1:STEP];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(N - 1)) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    sum_d   = psum_cat[WIDTH+STEP-1:STEP];
                    cout_d  = chain_c[STEP];
                    // Last step holds the MSB cell: carry into MSB vs carry out of MSB.
                    ovf_d   = chain_c[STEP] ^ chain_c[STEP-1];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit/1-step and a 16-bit/4-step instance share the clock,
// reset and stimulus; dsel picks which one is driven and observed. Results are compared
// against a plain-arithmetic reference model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_in, sub_in, cin_in, dsel;
    logic [15:0] a_in, b_in;

    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    serial_adder #(.WIDTH(8), .STEP(1)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start_in & ~dsel),
        .sub   (sub_in),
        .cin   (cin_in),
        .a     (a_in[7:0]),
        .b     (b_in[7:0]),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8),
        .ovf   (ovf8)
    );

    serial_adder #(.WIDTH(16), .STEP(4)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start_in & dsel),
        .sub   (sub_in),
        .cin   (cin_in),
        .a     (a_in),
        .b     (b_in),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16),
        .ovf   (ovf16)
    );

    logic        busy_o, done_o, cout_o, ovf_o;
    logic [15:0] sum_o;
    assign busy_o = dsel ? busy16 : busy8;
    assign done_o = dsel ? done16 : done8;
    assign cout_o = dsel ? cout16 : cout8;
    assign ovf_o  = dsel ? ovf16  : ovf8;
    assign sum_o  = dsel ? sum16  : {8'h00, sum8};

    int          checks = 0;
    int          errors = 0;
    int unsigned w, n;
    logic [15:0] exp_sum, prev_sum, saved8;
    logic        exp_cout, exp_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Unsigned sum for cout/sum, signed range test for overflow.
    function automatic void ref_model(input int unsigned width, input logic [15:0] av,
                                      input logic [15:0] bv, input logic sv, input logic cv,
                                      output logic [15:0] s, output logic co, output logic ov);
        longint mask, half, ua, ubo, ub, t, sa, sb, r;
        mask = (longint'(1) << width) - 1;
        half = longint'(1) << (width - 1);
        ua   = longint'(av) & mask;
        ubo  = longint'(bv) & mask;
        ub   = sv ? (mask - ubo) : ubo;
        t    = ua + ub + (sv ? 1 : longint'(cv));
        s    = 16'(t & mask);
        co   = ((t >> width) & 1) != 0;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ubo >= half) ? ubo - 2 * half : ubo;
        r    = sv ? sa - sb : sa + sb + longint'(cv);
        ov   = (r >= half) || (r < -half);
    endfunction

    // Call at a negedge; returns at the negedge following the accepting edge.
    task automatic launch(input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input logic cv);
        a_in = av; b_in = bv; sub_in = sv; cin_in = cv; start_in = 1'b1;
        ref_model(w, av, bv, sv, cv, exp_sum, exp_cout, exp_ovf);
        @(posedge clk);
        @(negedge clk);
        start_in = 1'b0;
        check("busy_after_accept", busy_o, 1);
        check("done_after_accept", done_o, 0);
    endtask

    // Waits for done (bounded), checks latency and results; returns at the done negedge.
    task automatic finish(input bit disturb);
        int lat = 0;
        while (done_o !== 1'b1 && lat < 40) begin
            check("sum_hold_during_run", sum_o, prev_sum);
            if (disturb) begin
                a_in = 16'($urandom); b_in = 16'($urandom);
                sub_in = 1'($urandom); cin_in = 1'($urandom);
                start_in = (lat == 1);
            end
            @(negedge clk);
            lat++;
        end
        start_in = 1'b0;
        check("latency", lat, n);
        check("sum", sum_o, exp_sum);
        check("cout", cout_o, exp_cout);
        check("ovf", ovf_o, exp_ovf);
        check("busy_at_done", busy_o, 0);
        prev_sum = exp_sum;
    endtask

    task automatic after_done();
        @(negedge clk);
        check("done_pulse_width", done_o, 0);
        check("busy_idle", busy_o, 0);
        check("sum_held", sum_o, prev_sum);
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b0; sub_in = 1'b0; cin_in = 1'b0;
        a_in = '0; b_in = '0; dsel = 1'b0; w = 8; n = 8; prev_sum = '0;
        #1;
        check("reset_busy8", busy8, 0);
        check("reset_done8", done8, 0);
        check("reset_sum8", sum8, 0);
        check("reset_sum16", sum16, 0);
        check("reset_cout16", cout16, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy8", busy8, 0);
        check("idle_done8", done8, 0);

        // Signed overflow on add.
        launch(16'h007F, 16'h0001, 1'b0, 1'b0);
        finish(1'b0);
        check("t2_sum", sum_o, 16'h0080);
        check("t2_ovf", ovf_o, 1);
        after_done();

        // Subtract with borrow, then subtract with overflow.
        launch(16'h0005, 16'h0007, 1'b1, 1'b0);
        finish(1'b0);
        check("t3a_sum", sum_o, 16'h00FE);
        check("t3a_cout", cout_o, 0);
        after_done();
        launch(16'h0080, 16'h0001, 1'b1, 1'b1);
        finish(1'b0);
        check("t3b_sum", sum_o, 16'h007F);
        check("t3b_cout", cout_o, 1);
        after_done();

        // Reset between edges clears outputs without a clock edge.
        #2 rst = 1'b1;
        #1;
        check("async_rst_sum", sum8, 0);
        check("async_rst_cout", cout8, 0);
        check("async_rst_ovf", ovf8, 0);
        check("async_rst_busy", busy8, 0);
        #1 rst = 1'b0;
        prev_sum = '0;
        @(negedge clk);
        check("post_rst_busy", busy8, 0);

        // Carry-in wraps; operand changes and start pulses during RUN are ignored.
        launch(16'h00FF, 16'h0000, 1'b0, 1'b1);
        finish(1'b1);
        check("t4_cout", cout_o, 1);
        after_done();
        after_done();

        // Reset four cycles into RUN aborts without a done pulse.
        launch(16'h00C3, 16'h005A, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_sum", sum8, 0);
        check("abort_cout", cout8, 0);
        @(negedge clk);
        rst = 1'b0;
        prev_sum = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", done8, 0);
        end
        launch(16'h0012, 16'h0034, 1'b0, 1'b0);
        finish(1'b0);
        after_done();
        saved8 = prev_sum;

        // 16-bit, 4 bits per step; back-to-back start from DONE.
        dsel = 1'b1; w = 16; n = 4; prev_sum = '0;
        @(negedge clk);
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        finish(1'b0);
        check("t6_sum", sum_o, 16'h0000);
        check("t6_cout", cout_o, 1);
        launch(16'h1234, 16'h4321, 1'b1, 1'b0);
        finish(1'b0);
        after_done();

        for (int d = 0; d < 2; d++) begin
            if (d == 1) begin
                dsel = 1'b0; w = 8; n = 8; prev_sum = saved8;
                @(negedge clk);
            end
            for (int i = 0; i < 1000; i++) begin
                launch(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                finish((i % 7) == 0);
                if ($urandom_range(1, 0) == 1) after_done();
            end
            after_done();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
